alu_exec_unit: RTL
==================

# alu_exec_unit

Iterative execute unit that consumes the 4-bit ALU operation code produced by the ALU control decoder, together with two operands. It produces a registered result plus zero and overflow flags. Logic and arithmetic ops complete in one cycle; shifts run serially at one bit per cycle. It sits in the execute stage of the 2.5-stage pipeline behind valid/ready handshakes, so the pipeline can stall on long shifts.

## Interface
- WIDTH, 64: operand and result width in bits.
- SHAMT_W, 6: shift-amount width, equal to log2(WIDTH).

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of any in-flight op.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept a request; high only in IDLE.
- operation  input  4  ALU operation code (encoding below).
- op_a  input  WIDTH  first operand; the shift source for shifts.
- op_b  input  WIDTH  second operand; the shift amount is op_b[SHAMT_W-1:0].
- out_valid  output  1  result, zero and overflow are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  high when result == 0.
- overflow  output  1  signed overflow for ADD/SUB; 0 for all other ops.

## Operation
- Operation encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR, 0101 SLL, 0110 SRL.
  - Any other code executes as ADD.
- Arithmetic is modulo 2^WIDTH.
- Overflow:
  - ADD: a and b have the same sign, and the result sign differs from them.
  - SUB: a and b have different signs, and the result sign differs from a.
- SRL is logical: zero fill. Only the low SHAMT_W bits of op_b are used; upper bits are ignored.
- A request is accepted on a rising edge where in_valid && in_ready.
- Operands and operation are captured at acceptance. Input changes after acceptance have no effect.
- State machine:
  - IDLE: in_ready=1.
    - On accept of a non-shift op, or a shift with amount 0: compute, load result/flags, go to DONE.
    - On accept of a shift with amount n>0: load shift register with op_a and counter with n, go to SHIFT.
  - SHIFT: each edge shifts the register one bit in the requested direction and decrements the counter. On the edge where the counter goes 1->0, load result, set zero, clear overflow, go to DONE.
  - DONE: out_valid=1; result and flags are held stable. On an edge with out_ready=1, go to IDLE.
- in_ready is 0 in SHIFT and DONE. There is no accept in the same cycle a result is consumed.
- flush=1 on an edge forces IDLE from any state and discards the op. flush has priority over accept and consume.
- flush does not clear result, zero or overflow; it clears only out_valid.
- Reset values: state IDLE; result 0, zero 0, overflow 0, out_valid 0, in_ready 1, internal counter 0.
- Asynchronous reset asserted mid-SHIFT or mid-DONE: the op is lost and the outputs return to their reset values immediately.

## Timing
- Acceptance edge E0.
- Non-shift op, or shift with amount 0: out_valid is high in the cycle after E0 (1-cycle latency).
- Shift with amount n>0: out_valid rises after edge E0+n. WIDTH-1=63 gives the maximum 63-cycle latency.
- out_valid stays high until the edge where out_ready=1. in_ready returns high in the following cycle.
- Peak throughput is one non-shift op per 2 cycles.
- result, zero and overflow are register outputs with no combinational path from inputs.
- in_ready is decoded from state only.

## Test plan
- Reset, then ADD a=5 b=7 with out_ready=1 -> out_valid one cycle after accept, result=12, zero=0, overflow=0; in_ready=0 while DONE, then 1 again.
- SUB a=0x7FFF_FFFF_FFFF_FFFF b=0xFFFF_FFFF_FFFF_FFFF (-1) -> result=0x8000_0000_0000_0000, overflow=1. Then SUB a=9 b=9 -> result=0, zero=1.
- SLL a=1, b=0x43 (low 6 bits = 3) -> out_valid 3 cycles after accept, result=8. SRL a=0x8000_0000_0000_0000 b=63 -> result=1 after 63 cycles. SLL b=0 -> result=a after 1 cycle.
- Code 1111, a=2 b=3 -> result=5 (ADD default). AND/OR/XOR with a=0xF0 b=0x3C -> 0x30, 0xFC, 0xCC.
- Hold out_ready=0 for 10 cycles in DONE -> result and flags stable, in_ready=0, and a new in_valid is ignored. Raise out_ready -> IDLE next cycle.
- SLL by 40 with flush at cycle 5 -> IDLE next edge, out_valid never asserts, next request accepted normally. Repeat with rst_n low mid-shift -> outputs immediately at reset values.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: iterative execute stage. Logic and arithmetic ops finish in
// one cycle. Shifts run serially, one bit per cycle. Requests arrive and
// results leave through valid/ready handshakes.
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. in_ready depends on state only (high in IDLE).
// out_valid stays high, with result/zero/overflow held stable, until the edge
// where out_ready is high. flush overrides both handshakes on any edge.
module alu_exec_unit #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;

  localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               left_q, left_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   sum, diff, alu_res, shifted;
  logic [SHAMT_W-1:0] amt;
  logic               is_shift, alu_ovf;

  assign amt      = op_b[SHAMT_W-1:0];
  assign is_shift = (operation == OP_SLL) || (operation == OP_SRL);
  assign sum      = op_a + op_b;
  assign diff     = op_a - op_b;
  assign shifted  = left_q ? (shreg_q << 1) : (shreg_q >> 1);

  // Single-cycle datapath; a zero-amount shift simply passes op_a through.
  always_comb begin
    alu_res = sum;
    alu_ovf = 1'b0;
    case (operation)
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_SLL,
      OP_SRL: alu_res = op_a;
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      default: begin
        alu_res = sum;
        alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
    endcase
  end

  // Next-state and datapath-register update; flush wins over accept/consume.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (!flush && in_valid) begin
          if (is_shift && (amt != '0)) begin
            shreg_d = op_a;
            cnt_d   = amt;
            left_d  = (operation == OP_SLL);
            state_d = S_SHIFT;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            state_d  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          shreg_d = shifted;
          cnt_d   = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            result_d = shifted;
            zero_d   = (shifted == '0);
            ovf_d    = 1'b0;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (flush || out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule
